// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - state type and magnitude helper shared by the divider files
package div_pkg;

  // One bit wider than the largest legal WIDTH, so callers always have spare upper bits
  localparam int MAG_W = 65;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;

  function automatic logic [MAG_W-1:0] mag(input logic [MAG_W-1:0] v, input logic neg);
    return neg ? (~v + MAG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// rtl/nr_div_step.sv - one combinational non-restoring division step on the AQ pair
module nr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] m_ext;

  always_comb begin
    a_sh   = {a[WIDTH-1:0], q[WIDTH-1]};
    m_ext  = {1'b0, m};
    a_next = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
    q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};
  end

endmodule

// File: rtl/div_seq_param.sv
// rtl/div_seq_param.sv - sequential signed/unsigned non-restoring divider, optional DIV_OVF_FLAG_EN
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
`ifdef DIV_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  div_state_t state;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_mag;
  logic [CNT_W-1:0] cnt;
  logic             sq;
  logic             sm;

  logic             in_sq;
  logic             in_sm;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [MAG_W-WIDTH-1:0] unused_dvd_hi;
  logic [MAG_W-WIDTH-1:0] unused_dvs_hi;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_mag;

  assign in_sq = is_signed & dividend[WIDTH-1];
  assign in_sm = is_signed & divisor[WIDTH-1];
  // |MIN| lands on 2^(WIDTH-1), which the unsigned magnitude datapath handles directly
  assign {unused_dvd_hi, dvd_mag} = mag(MAG_W'(dividend), in_sq);
  assign {unused_dvs_hi, dvs_mag} = mag(MAG_W'(divisor), in_sm);

  // Final restore only affects the low WIDTH bits; the sign bit is not needed afterwards
  assign r_mag = a_reg[WIDTH] ? (a_reg[WIDTH-1:0] + m_mag) : a_reg[WIDTH-1:0];

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_reg),
    .q      (q_reg),
    .m      (m_mag),
    .a_next (a_step),
    .q_next (q_step)
  );

`ifdef DIV_OVF_FLAG_EN
  logic ovf_pend;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      a_reg       <= '0;
      q_reg       <= '0;
      m_mag       <= '0;
      cnt         <= '0;
      sq          <= 1'b0;
      sm          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_OVF_FLAG_EN
      ovf_pend    <= 1'b0;
      ovf         <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sq          <= in_sq;
            sm          <= in_sm;
            m_mag       <= dvs_mag;
            a_reg       <= '0;
            q_reg       <= dvd_mag;
            cnt         <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_OVF_FLAG_EN
            ovf_pend    <= is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
            ovf         <= 1'b0;
`endif
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          a_reg <= a_step;
          q_reg <= q_step;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= (sq ^ sm) ? -q_reg : q_reg;
          remainder <= sq ? -r_mag : r_mag;
          busy      <= 1'b0;
          done      <= 1'b1;
`ifdef DIV_OVF_FLAG_EN
          ovf       <= ovf_pend;
`endif
          state     <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// tb/tb_div_seq_param.sv - randomized scoreboard bench for div_seq_param at WIDTH 32 and 8
module tb_div_seq_param;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        start, is_signed, busy, done, div_by_zero;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic        start8, is_signed8, busy8, done8, div_by_zero8;
  logic [7:0]  dividend8, divisor8, quotient8, remainder8;
`ifdef DIV_OVF_FLAG_EN
  logic        ovf, ovf8;
`endif

  div_seq_param #(.WIDTH(32)) dut32 (
    .clk(clk), .resetn(resetn), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
`ifdef DIV_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  div_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .is_signed(is_signed8),
    .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(div_by_zero8)
`ifdef DIV_OVF_FLAG_EN
    , .ovf(ovf8)
`endif
  );

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    bit          dbz;
    bit          ovf;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t e32, e8;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_cnt32 = 0;
  int done_cnt8 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint sx(logic [63:0] v, int w);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction

  // Reference: plain integer division, truncating toward zero, remainder follows the dividend
  function automatic exp_t model(int w, bit s, logic [63:0] a, logic [63:0] b);
    exp_t e;
    logic [63:0] mask;
    longint x, y;
    mask = (64'd1 << w) - 64'd1;
    e.t0 = 0; e.ovf = 0; e.dbz = 0; e.lat = w + 2;
    if (b == 64'd0) begin
      e.q = mask; e.r = a; e.dbz = 1; e.lat = 1;
    end else if (s) begin
      x = sx(a, w);
      y = sx(b, w);
      e.q = 64'(x / y) & mask;
      e.r = 64'(x % y) & mask;
      e.ovf = (y == -1) && (x == -(longint'(1) << (w - 1)));
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (resetn && done) begin
      done_cnt32++;
      if (sb32.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_done32: got done, required none (t=%0t)", $time);
      end else begin
        e32 = sb32.pop_front();
        check("quotient32", 64'(quotient), e32.q);
        check("remainder32", 64'(remainder), e32.r);
        check("dbz32", 64'(div_by_zero), 64'(e32.dbz));
        check("latency32", 64'(cyc - e32.t0), 64'(e32.lat));
`ifdef DIV_OVF_FLAG_EN
        check("ovf32", 64'(ovf), 64'(e32.ovf));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && done8) begin
      done_cnt8++;
      if (sb8.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_done8: got done, required none (t=%0t)", $time);
      end else begin
        e8 = sb8.pop_front();
        check("quotient8", 64'(quotient8), e8.q);
        check("remainder8", 64'(remainder8), e8.r);
        check("dbz8", 64'(div_by_zero8), 64'(e8.dbz));
        check("latency8", 64'(cyc - e8.t0), 64'(e8.lat));
`ifdef DIV_OVF_FLAG_EN
        check("ovf8", 64'(ovf8), 64'(e8.ovf));
`endif
      end
    end
  end

  task automatic drive(int w, logic st, logic s, logic [63:0] a, logic [63:0] b);
    if (w == 32) begin
      start = st; is_signed = s; dividend = a[31:0]; divisor = b[31:0];
    end else begin
      start8 = st; is_signed8 = s; dividend8 = a[7:0]; divisor8 = b[7:0];
    end
  endtask

  function automatic int dcnt(int w);
    return (w == 32) ? done_cnt32 : done_cnt8;
  endfunction

  // keep=0 launches without expecting a result; repulse re-fires start mid-operation
  task automatic op(int w, bit s, logic [63:0] a, logic [63:0] b, bit keep, bit repulse);
    int base;
    exp_t e;
    @(negedge clk); #1;
    base = dcnt(w);
    drive(w, 1'b1, s, a, b);
    if (keep) begin
      e = model(w, s, a, b);
      e.t0 = cyc;
      if (w == 32) sb32.push_back(e); else sb8.push_back(e);
    end
    @(negedge clk); #1;
    drive(w, 1'b0, s, a, b);
    check("busy_after_start", 64'((w == 32) ? busy : busy8), 64'(b != 64'd0));
    check("dbz_after_start", 64'((w == 32) ? div_by_zero : div_by_zero8), 64'(b == 64'd0));
    if (keep) begin
      for (int i = 0; i < 100 && dcnt(w) == base; i++) begin
        if (repulse && i == 3) drive(w, 1'b1, ~s, 64'($urandom), 64'($urandom | 1));
        if (repulse && i == 4) drive(w, 1'b0, s, 64'($urandom), 64'($urandom | 1));
        @(negedge clk); #1;
      end
      if (dcnt(w) == base) begin
        compared++; mismatched++;
        $display("FAIL timeout_w%0d: got no done in 100 cycles, required done", w);
      end
    end
  endtask

  function automatic logic [63:0] rnd(int w, bit is_div);
    logic [63:0] mask, v;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0: v = is_div ? 64'd0 : (64'd1 << (w - 1));
      1: v = is_div ? mask : 64'd1;
      2: v = 64'($urandom_range(1, 9));
      default: v = {$urandom, $urandom};
    endcase
    return v & mask;
  endfunction

  initial begin
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_quotient8", 64'(quotient8), 64'd0);
    resetn = 1'b1;

    op(32, 0, 64'd38, 64'd6, 1, 0);
    op(32, 1, 64'(32'(-38)), 64'd6, 1, 0);
    op(32, 1, 64'd38, 64'(32'(-6)), 1, 0);
    op(32, 0, 64'd100, 64'd0, 1, 0);
    op(32, 0, 64'd38, 64'd6, 1, 0);
    op(32, 0, 64'hFFFF_FFFF, 64'd1, 1, 0);
    op(32, 1, 64'h8000_0000, 64'hFFFF_FFFF, 1, 0);
    op(32, 0, 64'h8000_0000, 64'hFFFF_FFFF, 1, 0);
    op(32, 1, 64'd1000, 64'd7, 1, 1);

    // A divide-by-zero start during the done cycle must be dropped
    op(32, 0, 64'd77, 64'd5, 1, 0);
    drive(32, 1'b1, 1'b0, 64'd5, 64'd0);
    @(negedge clk); #1;
    drive(32, 1'b0, 1'b0, 64'd5, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("ignored_start_busy", 64'(busy), 64'd0);
    check("ignored_start_dbz", 64'(div_by_zero), 64'd0);

    for (int k = 0; k < 40; k++) op(32, 1'($urandom_range(0, 1)), rnd(32, 0), rnd(32, 1), 1, 0);

    op(8, 0, 64'd200, 64'd7, 1, 0);
    op(8, 1, 64'h80, 64'hFF, 1, 0);
    for (int k = 0; k < 15; k++) op(8, 1'($urandom_range(0, 1)), rnd(8, 0), rnd(8, 1), 1, 0);

    op(32, 0, 64'd38, 64'd6, 1, 0);
    op(32, 0, 64'd500, 64'd3, 0, 0);
    repeat (8) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midop_rst_busy", 64'(busy), 64'd0);
    check("midop_rst_done", 64'(done), 64'd0);
    check("midop_rst_quotient", 64'(quotient), 64'd0);
    check("midop_rst_remainder", 64'(remainder), 64'd0);
    check("midop_rst_dbz", 64'(div_by_zero), 64'd0);
    check("midop_rst_quotient8", 64'(quotient8), 64'd0);
    @(negedge clk); #1;
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    op(32, 1, 64'(32'(-7)), 64'd2, 1, 0);

    repeat (3) @(negedge clk);
    if (sb32.size() != 0 || sb8.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL pending_results: got %0d/%0d outstanding, required 0", sb32.size(), sb8.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
